// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, keycodes, status bit indices and helpers for game_sequencer
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAYING = 3'd1,
        S_PAUSED  = 3'd2,
        S_WIN     = 3'd3,
        S_LOSE    = 3'd4,
        S_RESTART = 3'd5
    } state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;

    localparam int STATUS_PLAYING = 0;
    localparam int STATUS_WIN     = 1;
    localparam int STATUS_LOSE    = 2;
    localparam int STATUS_RESTART = 3;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // IDLE and PAUSED deliberately share the all-zero encoding.
    function automatic logic [3:0] status_of(input state_t s);
        logic [3:0] st;
        st = 4'b0000;
        case (s)
            S_PLAYING: st[STATUS_PLAYING] = 1'b1;
            S_WIN:     st[STATUS_WIN]     = 1'b1;
            S_LOSE:    st[STATUS_LOSE]    = 1'b1;
            S_RESTART: st[STATUS_RESTART] = 1'b1;
            default:   st = 4'b0000;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - synchronizes frame_clk into Clk and emits one pulse per rising edge
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync_meta;
    logic sync_q;
    logic sync_d;

    // Edge history clears on reset, so a new synchronized 0->1 is needed before the first tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            sync_d     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync_meta  <= frame_clk;
            sync_q     <= sync_meta;
            sync_d     <= sync_q;
            frame_tick <= sync_q & ~sync_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round state machine with frame timer, coin score and registered status
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [3:0]  WIN_COINS   = 4'd10,
    parameter logic [11:0] FRAME_LIMIT = 12'd3600
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        collide,
    input  logic [2:0]  coin_hit,
    output logic [3:0]  status,
    output logic [11:0] frame_counter,
    output logic [3:0]  coin_count,
    output logic        frame_tick
);

    state_t     state;
    state_t     state_next;
    logic [7:0] prev_key;
    logic       press_space;
    logic       press_enter;
    logic       press_p;
    logic       lose_cond;
    logic       win_cond;
    logic [4:0] coin_sum;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign press_space = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);
    assign press_enter = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
    assign press_p     = (keycode == KEY_P)     && (prev_key != KEY_P);

    assign lose_cond = collide || (frame_counter == FRAME_LIMIT);
    assign win_cond  = (coin_count >= WIN_COINS);
    assign coin_sum  = {1'b0, coin_count} + {3'b000, popcount3(coin_hit)};

    // Lose beats win, and both beat a pause request in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (press_space) state_next = S_PLAYING;
            S_PLAYING: begin
                if (lose_cond)     state_next = S_LOSE;
                else if (win_cond) state_next = S_WIN;
                else if (press_p)  state_next = S_PAUSED;
            end
            S_PAUSED: begin
                if (press_p)          state_next = S_PLAYING;
                else if (press_enter) state_next = S_RESTART;
            end
            S_WIN, S_LOSE: if (press_enter) state_next = S_RESTART;
            S_RESTART: if (frame_tick) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            status        <= 4'b0000;
            prev_key      <= 8'h00;
            frame_counter <= 12'd0;
            coin_count    <= 4'd0;
        end else begin
            state    <= state_next;
            status   <= status_of(state_next);
            prev_key <= keycode;
            case (state)
                S_IDLE: begin
                    if (press_space) begin
                        frame_counter <= 12'd0;
                        coin_count    <= 4'd0;
                    end
                end
                S_PLAYING: begin
                    if (frame_tick && (frame_counter < FRAME_LIMIT))
                        frame_counter <= frame_counter + 12'd1;
                    coin_count <= (coin_sum > 5'd15) ? 4'd15 : coin_sum[3:0];
                end
                S_RESTART: begin
                    frame_counter <= 12'd0;
                    coin_count    <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter WIN_COINS, default 4'd10: coin_count value that ends a round as a win.
REQ-002 Parameter FRAME_LIMIT, default 12'd3600: frame_counter value that ends a round as a loss (60 s at 60 Hz).
REQ-003 Clk  in  1  system clock, 50 MHz; sole clock of the block.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 frame_clk  in  1  VGA_VS from the VGA controller, asynchronous to Clk.
REQ-006 keycode  in  8  current USB HID keycode; 0x00 means no key.
REQ-007 collide  in  1  stickman/obstacle hit, level-sensitive.
REQ-008 coin_hit  in  3  one bit per coin slot, single-cycle pulse per pickup.
REQ-009 status  out  4  bit0 playing, bit1 win, bit2 lose, bit3 restart.
REQ-010 frame_counter  out  12  frames elapsed in the current round.
REQ-011 coin_count  out  4  coins collected in the current round.
REQ-012 frame_tick  out  1  single-Clk pulse, one per frame_clk rising edge.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer; frame_tick SHALL assert on the cycle after the synchronized value goes from 0 to 1 (3-cycle latency).
REQ-014 A key press event SHALL fire when keycode == K and the keycode registered on the previous cycle != K; a held key SHALL fire once only.
REQ-015 States: IDLE, PLAYING, PAUSED, WIN, LOSE, RESTART.
REQ-016 IDLE -> PLAYING on a SPACE (0x2C) press; coin_count and frame_counter SHALL clear on entry.
REQ-017 PLAYING -> PAUSED on a P (0x13) press; PAUSED -> PLAYING on a P press. Counters SHALL freeze while PAUSED.
REQ-018 PLAYING -> LOSE when collide == 1, or when frame_counter == FRAME_LIMIT.
REQ-019 PLAYING -> WIN when coin_count >= WIN_COINS.
REQ-020 If LOSE and WIN conditions hold in the same cycle, LOSE SHALL take priority.
REQ-021 WIN, LOSE, or PAUSED -> RESTART on an ENTER (0x28) press.
REQ-022 RESTART SHALL hold until the next frame_tick, then go to IDLE. This guarantees that every frame_clk-driven module samples restart for one full frame.
REQ-023 In PLAYING only, frame_counter SHALL increment by 1 on each frame_tick and saturate at FRAME_LIMIT.
REQ-024 In PLAYING only, coin_count SHALL add the popcount of coin_hit every cycle, saturating at 15.
REQ-025 coin_hit and collide SHALL be ignored outside PLAYING.
REQ-026 In the same cycle, a P press SHALL lose priority to a LOSE/WIN transition.
REQ-027 status SHALL be registered and one-hot over bits 0..3:
  - PLAYING -> 0001
  - WIN -> 0010
  - LOSE -> 0100
  - RESTART -> 1000
  - IDLE and PAUSED -> 0000
REQ-028 status SHALL change on the cycle after the transition condition.
REQ-029 frame_counter and coin_count SHALL keep their final values in WIN and LOSE for score display, and clear in RESTART.

Reset
REQ-030 Reset SHALL force the following, taking priority over every input including mid-round and mid-RESTART:
  - state = IDLE
  - status = 0000
  - frame_counter = 0
  - coin_count = 0
  - frame_tick = 0
  - synchronizer flops = 0
  - previous-keycode register = 0x00
REQ-031 The first frame_tick after reset SHALL require a new 0->1 edge on synchronized frame_clk.

Structure
REQ-032 Package game_pkg SHALL hold the state enum, the keycode constants KEY_SPACE, KEY_ENTER and KEY_P, and the status bit indices.
REQ-033 Sub-module frame_tick_gen SHALL contain the synchronizer and edge detector.
REQ-034 Target size is 150-250 lines of RTL.

Verification
REQ-035 Reset, then drive frame_clk at 60 Hz equivalent -> exactly one frame_tick per rising edge, 3 cycles after it; status = 0000.
REQ-036 Hold SPACE (0x2C) for 100 cycles -> single transition to PLAYING; status = 0001; after 5 frame_ticks, frame_counter = 5.
REQ-037 In PLAYING, pulse coin_hit = 3'b111 in 3 consecutive cycles, then 3'b001 once -> coin_count = 10; next cycle status = 0010.
REQ-038 In PLAYING with coin_count = 9, assert collide and coin_hit = 3'b001 in the same cycle -> status = 0100; coin_count = 10 retained.
REQ-039 Press P, wait 10 frames, press P -> frame_counter unchanged across the pause; collide asserted during PAUSED is ignored.
REQ-040 From LOSE, press ENTER -> status = 1000 until the next frame_tick, then 0000 with both counters at 0. Separately, assert Reset in the middle of RESTART -> IDLE on the next cycle.
